// File: rtl/wb_mon_pkg.sv
// wb_mon_pkg: shared definitions for the Wishbone B4 pipelined slave protocol monitor.
//   - NUM_CHECKS and the CHK_* bit indices of the violation vector
//   - mon_state_e : bus activity state {IDLE, ACTIVE, WAIT}
//   - wb_req_t    : request snapshot captured during a stalled strobe
//   - lowest_index: index of the lowest set bit of a check vector
`timescale 1ns/1ps
package wb_mon_pkg;

  localparam int NUM_CHECKS    = 7;
  localparam int CHK_ACK_ERR   = 0;
  localparam int CHK_SPURIOUS  = 1;
  localparam int CHK_TIMEOUT   = 2;
  localparam int CHK_OVERFLOW  = 3;
  localparam int CHK_STB_NOCYC = 4;
  localparam int CHK_ABORT     = 5;
  localparam int CHK_STALL_CHG = 6;

  // Snapshot fields are sized for the widest supported bus. Narrower buses
  // zero-extend into them, so one struct type serves every parametrisation.
  localparam int WB_ADR_MAX = 64;
  localparam int WB_DAT_MAX = 256;
  localparam int WB_SEL_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [WB_ADR_MAX-1:0] adr;
    logic                  we;
    logic [WB_SEL_MAX-1:0] sel;
    logic [WB_DAT_MAX-1:0] dat;
  } wb_req_t;

  // Lowest set index wins, so simultaneous violations report deterministically.
  function automatic logic [2:0] lowest_index(input logic [NUM_CHECKS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_mon_sat_counter.sv
// wb_mon_sat_counter: up-counter that saturates at all-ones.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : increment request
//   cnt        : registered count
`timescale 1ns/1ps
module wb_mon_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {WIDTH{1'b0}};
    end else if (clr) begin
      cnt <= {WIDTH{1'b0}};
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/wb_slave_protocol_monitor.sv
// wb_slave_protocol_monitor: passive Wishbone B4 pipelined-mode checker.
// It observes a slave's bus and raises registered, sticky violation flags.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   cyc_i..sel_i         : observed master signals
//   ack_o, err_o, stall_o: observed slave responses (inputs here)
//   check_en_i           : per-check enable
//   clear_i              : clears flags, first-violation record and counters
//   viol_o, viol_pulse_o : sticky flags, pulse on any newly set flag
//   first_id_o/vld_o     : first violation since the last clear
//   outstanding_o        : accepted-but-unanswered requests
//   ack_cnt_o, err_cnt_o : saturating response counters
`timescale 1ns/1ps
module wb_slave_protocol_monitor
  import wb_mon_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int GRANULE         = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     cyc_i,
  input  logic                                     stb_i,
  input  logic                                     we_i,
  input  logic [ADDR_WIDTH-1:0]                    adr_i,
  input  logic [DATA_WIDTH-1:0]                    dat_i,
  input  logic [DATA_WIDTH/GRANULE-1:0]            sel_i,
  input  logic                                     ack_o,
  input  logic                                     err_o,
  input  logic                                     stall_o,
  input  logic [NUM_CHECKS-1:0]                    check_en_i,
  input  logic                                     clear_i,
  output logic [NUM_CHECKS-1:0]                    viol_o,
  output logic                                     viol_pulse_o,
  output logic [2:0]                               first_id_o,
  output logic                                     first_vld_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic [CNT_WIDTH-1:0]                     ack_cnt_o,
  output logic [CNT_WIDTH-1:0]                     err_cnt_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  mon_state_e            state_r;
  logic [OUT_W-1:0]      out_r;
  logic [OUT_W-1:0]      out_next_s;
  logic                  stall_pend_r;
  wb_req_t               snap_r;
  wb_req_t               cur_req_s;
  logic [NUM_CHECKS-1:0] viol_r;
  logic [NUM_CHECKS-1:0] hit_s;
  logic [NUM_CHECKS-1:0] new_s;
  logic [NUM_CHECKS-1:0] viol_next_s;
  logic                  pulse_r;
  logic [2:0]            first_id_r;
  logic [2:0]            first_id_next_s;
  logic                  first_vld_r;
  logic                  first_vld_next_s;
  logic                  accept_s;
  logic                  resp_s;
  logic                  req_chg_s;
  logic                  tmo_hit_s;
  logic                  tmo_clr_s;
  logic [TMO_W-1:0]      tmo_cnt_s;

  // Bus decode, outstanding update, check evaluation and flag/first-id next state.
  always_comb begin
    accept_s = cyc_i & stb_i & ~stall_o;
    resp_s   = cyc_i & (ack_o | err_o);

    // Clamping keeps the count meaningful after a protocol error; the
    // offending event itself is reported by SPURIOUS or OVERFLOW.
    if (!cyc_i) begin
      out_next_s = OUT_ZERO;
    end else if (accept_s && !resp_s) begin
      out_next_s = (out_r == OUT_MAX) ? out_r : (out_r + OUT_ONE);
    end else if (resp_s && !accept_s) begin
      out_next_s = (out_r == OUT_ZERO) ? out_r : (out_r - OUT_ONE);
    end else begin
      out_next_s = out_r;
    end

    // The timer restarts after each expiry so a hung slave keeps re-flagging.
    tmo_hit_s = ~resp_s & (out_r != OUT_ZERO) & (tmo_cnt_s == TMO_LAST);
    tmo_clr_s = resp_s | (out_r == OUT_ZERO) | tmo_hit_s;

    cur_req_s.adr = WB_ADR_MAX'(adr_i);
    cur_req_s.we  = we_i;
    cur_req_s.sel = WB_SEL_MAX'(sel_i);
    cur_req_s.dat = WB_DAT_MAX'(dat_i);
    req_chg_s = (cur_req_s.adr != snap_r.adr) | (cur_req_s.we != snap_r.we) |
                (cur_req_s.sel != snap_r.sel) |
                (snap_r.we & (cur_req_s.dat != snap_r.dat));

    hit_s                = {NUM_CHECKS{1'b0}};
    hit_s[CHK_ACK_ERR]   = ack_o & err_o;
    hit_s[CHK_SPURIOUS]  = resp_s & (out_r == OUT_ZERO) & ~accept_s;
    hit_s[CHK_TIMEOUT]   = tmo_hit_s;
    hit_s[CHK_OVERFLOW]  = accept_s & (out_r == OUT_MAX) & ~resp_s;
    hit_s[CHK_STB_NOCYC] = stb_i & ~cyc_i;
    // WAIT is only reachable with cyc_i high last cycle, so this is a falling cyc_i.
    hit_s[CHK_ABORT]     = (state_r == ST_WAIT) & ~cyc_i;
    hit_s[CHK_STALL_CHG] = stall_pend_r & stb_i & req_chg_s;
    hit_s                = hit_s & check_en_i;

    // A violation coinciding with clear_i survives the clear.
    if (clear_i) begin
      new_s       = hit_s;
      viol_next_s = hit_s;
    end else begin
      new_s       = hit_s & ~viol_r;
      viol_next_s = viol_r | hit_s;
    end

    if (clear_i) begin
      first_vld_next_s = |hit_s;
      first_id_next_s  = lowest_index(hit_s);
    end else if (!first_vld_r && (|new_s)) begin
      first_vld_next_s = 1'b1;
      first_id_next_s  = lowest_index(new_s);
    end else begin
      first_vld_next_s = first_vld_r;
      first_id_next_s  = first_id_r;
    end
  end

  // Bus activity FSM; it follows the outstanding count it will hold next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACTIVE, ST_WAIT: begin
          if (!cyc_i) begin
            state_r <= ST_IDLE;
          end else if (out_next_s == OUT_ZERO) begin
            state_r <= ST_ACTIVE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Outstanding count, stall snapshot and violation reporting registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_r        <= OUT_ZERO;
      stall_pend_r <= 1'b0;
      snap_r       <= {$bits(wb_req_t){1'b0}};
      viol_r       <= {NUM_CHECKS{1'b0}};
      pulse_r      <= 1'b0;
      first_id_r   <= 3'd0;
      first_vld_r  <= 1'b0;
    end else begin
      out_r        <= out_next_s;
      stall_pend_r <= cyc_i & stb_i & stall_o;
      snap_r       <= cur_req_s;
      viol_r       <= viol_next_s;
      pulse_r      <= |new_s;
      first_id_r   <= first_id_next_s;
      first_vld_r  <= first_vld_next_s;
    end
  end

  wb_mon_sat_counter #(.WIDTH(CNT_WIDTH)) u_ack_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clear_i),
    .inc   (resp_s & ack_o),
    .cnt   (ack_cnt_o)
  );

  wb_mon_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clear_i),
    .inc   (resp_s & err_o),
    .cnt   (err_cnt_o)
  );

  wb_mon_sat_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (tmo_clr_s),
    .inc   (1'b1),
    .cnt   (tmo_cnt_s)
  );

  assign viol_o        = viol_r;
  assign viol_pulse_o  = pulse_r;
  assign first_id_o    = first_id_r;
  assign first_vld_o   = first_vld_r;
  assign outstanding_o = out_r;

endmodule

// File: tb/tb_wb_slave_protocol_monitor.sv
`timescale 1ns/1ps
module tb_wb_slave_protocol_monitor;

  localparam int MAXO = 4;
  localparam int TMO  = 16;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_ni, cyc_i, stb_i, we_i, ack_o, err_o, stall_o, clear_i;
  logic [15:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [6:0]  check_en_i;
  logic [6:0]  viol_o;
  logic        viol_pulse_o, first_vld_o;
  logic [2:0]  first_id_o;
  logic [2:0]  outstanding_o;
  logic [15:0] ack_cnt_o, err_cnt_o;

  // Reference model state
  int          m_out, m_age, m_ack, m_err;
  logic        m_hist, m_we, m_pulse, m_fvld;
  logic [15:0] m_adr;
  logic [3:0]  m_sel;
  logic [31:0] m_dat;
  logic [6:0]  m_viol;
  logic [2:0]  m_fid;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  wb_slave_protocol_monitor dut (
    .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .ack_o(ack_o), .err_o(err_o),
    .stall_o(stall_o), .check_en_i(check_en_i), .clear_i(clear_i),
    .viol_o(viol_o), .viol_pulse_o(viol_pulse_o), .first_id_o(first_id_o),
    .first_vld_o(first_vld_o), .outstanding_o(outstanding_o),
    .ack_cnt_o(ack_cnt_o), .err_cnt_o(err_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_age = 0; m_ack = 0; m_err = 0;
    m_hist = 1'b0; m_we = 1'b0; m_adr = 16'h0; m_sel = 4'h0; m_dat = 32'h0;
    m_viol = 7'h0; m_pulse = 1'b0; m_fid = 3'd0; m_fvld = 1'b0;
  endtask

  function automatic logic [2:0] first_set(input logic [6:0] v);
    for (int i = 0; i < 7; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic       acc, rsp;
    logic [6:0] hit, newly;
    int         nxt;
    acc = cyc_i & stb_i & ~stall_o;
    rsp = cyc_i & (ack_o | err_o);
    hit = 7'h0;
    hit[0] = ack_o & err_o;
    hit[1] = rsp & (m_out == 0) & ~acc;
    if (rsp || m_out == 0) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == TMO) begin
        hit[2] = 1'b1;
        m_age = 0;
      end
    end
    hit[3] = acc & (m_out == MAXO) & ~rsp;
    hit[4] = stb_i & ~cyc_i;
    hit[5] = ~cyc_i & (m_out > 0);
    hit[6] = m_hist & stb_i & ((adr_i != m_adr) | (we_i != m_we) | (sel_i != m_sel) |
                               (we_i & (dat_i != m_dat)));
    hit = hit & check_en_i;
    if (!cyc_i) begin
      m_out = 0;
    end else begin
      nxt = m_out + (acc ? 1 : 0) - (rsp ? 1 : 0);
      m_out = (nxt < 0) ? 0 : ((nxt > MAXO) ? MAXO : nxt);
    end
    m_hist = cyc_i & stb_i & stall_o;
    m_adr = adr_i; m_we = we_i; m_sel = sel_i; m_dat = dat_i;
    newly = clear_i ? hit : (hit & ~m_viol);
    m_pulse = |newly;
    m_viol = clear_i ? hit : (m_viol | hit);
    if (clear_i) begin
      m_fvld = |hit;
      m_fid = first_set(hit);
    end else if (!m_fvld && (|newly)) begin
      m_fvld = 1'b1;
      m_fid = first_set(newly);
    end
    if (clear_i) begin
      m_ack = 0;
      m_err = 0;
    end else begin
      if (rsp && ack_o && m_ack < CMAX) m_ack++;
      if (rsp && err_o && m_err < CMAX) m_err++;
    end
  endtask

  task automatic check_all();
    chk("viol", 32'(viol_o), 32'(m_viol));
    chk("pulse", 32'(viol_pulse_o), 32'(m_pulse));
    chk("first_id", 32'(first_id_o), 32'(m_fid));
    chk("first_vld", 32'(first_vld_o), 32'(m_fvld));
    chk("outstanding", 32'(outstanding_o), 32'(m_out));
    chk("ack_cnt", 32'(ack_cnt_o), 32'(m_ack));
    chk("err_cnt", 32'(err_cnt_o), 32'(m_err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_viol"}, 32'(viol_o), 32'h0);
    chk({tag, "_pulse"}, 32'(viol_pulse_o), 32'h0);
    chk({tag, "_fid"}, 32'(first_id_o), 32'h0);
    chk({tag, "_fvld"}, 32'(first_vld_o), 32'h0);
    chk({tag, "_out"}, 32'(outstanding_o), 32'h0);
    chk({tag, "_ack"}, 32'(ack_cnt_o), 32'h0);
    chk({tag, "_err"}, 32'(err_cnt_o), 32'h0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drv(input logic c, input logic s, input logic w, input logic [15:0] a,
                     input logic st, input logic ak, input logic er);
    cyc_i = c; stb_i = s; we_i = w; adr_i = a; stall_o = st; ack_o = ak; err_o = er;
    clear_i = 1'b0;
  endtask

  task automatic do_clear();
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    step();
  endtask

  initial begin
    rst_ni = 1'b0;
    check_en_i = 7'h7F;
    dat_i = 32'hA5A5_0001;
    sel_i = 4'hF;
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check_zero("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // 1: three-beat write burst, acks follow
    drv(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 1'b1, 1'b1, 16'h0104, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 1'b1, 1'b1, 16'h0108, 1'b0, 1'b0, 1'b0); step();
    chk("t1_out3", 32'(outstanding_o), 32'd3);
    drv(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); step();
    chk("t1_ack", 32'(ack_cnt_o), 32'd3);
    chk("t1_viol", 32'(viol_o), 32'h0);

    // 2: ack and err together
    do_clear();
    drv(1'b1, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b1, 1'b1); step();
    chk("t2_viol", 32'(viol_o), 32'h01);
    chk("t2_fid", 32'(first_id_o), 32'd0);
    chk("t2_ack", 32'(ack_cnt_o), 32'd1);
    chk("t2_err", 32'(err_cnt_o), 32'd1);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); step();

    // 3: timeout then abort
    do_clear();
    drv(1'b1, 1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    repeat (15) step();
    chk("t3_no_tmo_yet", 32'(viol_o[2]), 32'd0);
    step();
    chk("t3_tmo", 32'(viol_o[2]), 32'd1);
    repeat (3) step();
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); step();
    chk("t3_abort", 32'(viol_o[5]), 32'd1);
    chk("t3_out", 32'(outstanding_o), 32'd0);
    chk("t3_fid", 32'(first_id_o), 32'd2);

    // 4: stall-phase change, then legal stb drop
    do_clear();
    drv(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0); step();
    drv(1'b1, 1'b1, 1'b0, 16'h0014, 1'b1, 1'b0, 1'b0); step();
    chk("t4_chg", 32'(viol_o), 32'h40);
    do_clear();
    drv(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0); step();
    drv(1'b1, 1'b0, 1'b0, 16'h0014, 1'b1, 1'b0, 1'b0); step();
    chk("t4_drop", 32'(viol_o), 32'h00);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); step();

    // 5: overflow, then clear with same-cycle stb without cyc
    do_clear();
    drv(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    chk("t5_ovf", 32'(viol_o[3]), 32'd1);
    chk("t5_clamp", 32'(outstanding_o), 32'd4);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); step();
    drv(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    step();
    chk("t5_viol", 32'(viol_o), 32'h10);
    chk("t5_fid", 32'(first_id_o), 32'd4);

    // 6: asynchronous reset mid-transaction
    drv(1'b1, 1'b1, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b0); step(); step();
    drv(1'b1, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b0); step();
    chk("t6_pre_out", 32'(outstanding_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("t6_async");
    model_reset();
    @(posedge clk); #1;
    check_zero("t6_held");
    rst_ni = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0); step();
    chk("t6_spurious", 32'(viol_o), 32'h02);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drv(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 3) * 4), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
      dat_i = ($urandom_range(0, 1) == 0) ? 32'hA5A5_0001 : 32'h5A5A_0002;
      sel_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'h3;
      if ($urandom_range(0, 15) == 0) check_en_i = 7'($urandom);
      clear_i = 1'($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
